// File: rtl/wshb_pattern_slave_if.sv
// Wishbone classic bus between the display controller (master) and a frame
// source (slave).
interface wshb_pattern_slave_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (output cyc, stb, we, adr, sel, dat_ms, input dat_sm, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_ms, output dat_sm, ack);
endinterface

// File: rtl/wshb_pattern_slave.sv
// Wishbone classic slave that synthesises framebuffer pixels from the address
// using a selectable test pattern, plus MODE/COLOR control registers.
module wshb_pattern_slave #(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  wshb_pattern_slave_if.slave   wshb
);

  localparam logic [29:0] NPIX      = 30'(HDISP * VDISP);
  localparam logic [29:0] HLEN      = 30'(HDISP);
  localparam logic [15:0] XLAST     = 16'(HDISP - 1);
  localparam logic [3:0]  WLAST     = 4'(WAIT_STATES - 1);
  localparam logic [31:0] MODE_ADR  = 32'h8000_0000;
  localparam logic [31:0] COLOR_ADR = 32'h8000_0004;

  typedef enum logic [2:0] {IDLE, SEEK, WAIT, ACK, GAP} state_t;

  state_t      state;
  logic [31:0] req_adr;
  logic        req_we;
  logic [2:0]  req_sel;
  logic [23:0] req_dat;
  logic [1:0]  mode;
  logic [23:0] color;
  logic        tr_valid;
  logic [29:0] tr_idx;
  logic [15:0] tr_x, tr_y;
  logic [29:0] rem;
  logic [15:0] seek_y;
  logic [3:0]  wait_cnt;

  logic [29:0] bus_idx;
  logic        bus_frame_rd, bus_oor_rd, hit_reuse, hit_adv;
  logic [15:0] adv_x, adv_y, hit_x, hit_y;
  logic        unused_bits;

  function automatic logic [31:0] respond(input logic [31:0] adr, input logic [7:0] x,
                                          input logic [7:0] y, input logic [1:0] m,
                                          input logic [23:0] c);
    logic [29:0] idx;
    logic [31:0] r;
    idx = adr[31:2];
    r   = '0;
    if (adr[31]) begin
      if (adr == MODE_ADR)       r = {30'b0, m};
      else if (adr == COLOR_ADR) r = {8'b0, c};
    end else if (idx < NPIX) begin
      case (m)
        2'd0:    r = {8'h00, c};
        2'd1:    r = {8'h00, x, y, 8'h80};
        2'd2:    r = (x[4] ^ y[4]) ? 32'h00FF_FFFF : 32'h0;
        default: r = {8'h00, idx[23:0]};
      endcase
    end
    return r;
  endfunction

  always_comb begin
    bus_idx      = wshb.adr[31:2];
    bus_frame_rd = !wshb.adr[31] && !wshb.we && (bus_idx < NPIX);
    bus_oor_rd   = !wshb.adr[31] && !wshb.we && (bus_idx >= NPIX);
    hit_reuse    = tr_valid && (bus_idx == tr_idx);
    hit_adv      = tr_valid && (bus_idx == tr_idx + 30'd1);
    // Sequential scan-out advances x and wraps to the next line at HDISP.
    adv_x = (tr_x == XLAST) ? 16'd0 : tr_x + 16'd1;
    adv_y = (tr_x == XLAST) ? tr_y + 16'd1 : tr_y;
    hit_x = hit_adv ? adv_x : tr_x;
    hit_y = hit_adv ? adv_y : tr_y;
    unused_bits = ^{wshb.dat_ms[31:24], wshb.sel[3]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register is reset here; there is no memory array whose
      // reset would be costly, and a clean restart simplifies bring-up.
      state     <= IDLE;
      wshb.ack  <= 1'b0;
      wshb.dat_sm <= '0;
      mode      <= '0;
      color     <= '0;
      tr_valid  <= 1'b0;
      tr_idx    <= '0;
      tr_x      <= '0;
      tr_y      <= '0;
      rem       <= '0;
      seek_y    <= '0;
      wait_cnt  <= '0;
      req_adr   <= '0;
      req_we    <= 1'b0;
      req_sel   <= '0;
      req_dat   <= '0;
    end else begin
      wshb.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (wshb.cyc && wshb.stb) begin
            req_adr <= wshb.adr;
            req_we  <= wshb.we;
            req_sel <= wshb.sel[2:0];
            req_dat <= wshb.dat_ms[23:0];
            if (bus_frame_rd && !(hit_reuse || hit_adv)) begin
              rem      <= bus_idx;
              seek_y   <= '0;
              tr_valid <= 1'b0;
              state    <= SEEK;
            end else begin
              if (bus_frame_rd && hit_adv) begin
                tr_idx <= bus_idx;
                tr_x   <= adv_x;
                tr_y   <= adv_y;
              end
              if (bus_oor_rd) tr_valid <= 1'b0;
              if (WAIT_STATES == 0) begin
                wshb.ack    <= 1'b1;
                wshb.dat_sm <= respond(wshb.adr, hit_x[7:0], hit_y[7:0], mode, color);
                state       <= ACK;
              end else begin
                wait_cnt <= '0;
                state    <= WAIT;
              end
            end
          end
        end
        SEEK: begin
          if (!wshb.cyc) begin
            state <= IDLE;
          end else if (rem >= HLEN) begin
            rem    <= rem - HLEN;
            seek_y <= seek_y + 16'd1;
          end else begin
            tr_valid <= 1'b1;
            tr_idx   <= req_adr[31:2];
            tr_x     <= rem[15:0];
            tr_y     <= seek_y;
            if (WAIT_STATES == 0) begin
              wshb.ack    <= 1'b1;
              wshb.dat_sm <= respond(req_adr, rem[7:0], seek_y[7:0], mode, color);
              state       <= ACK;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!wshb.cyc) begin
            state <= IDLE;
          end else if (wait_cnt == WLAST) begin
            wshb.ack    <= 1'b1;
            wshb.dat_sm <= respond(req_adr, tr_x[7:0], tr_y[7:0], mode, color);
            state       <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ACK: begin
          if (req_we && req_adr == MODE_ADR && req_sel[0]) mode <= req_dat[1:0];
          if (req_we && req_adr == COLOR_ADR) begin
            for (int i = 0; i < 3; i++)
              if (req_sel[i]) color[8*i +: 8] <= req_dat[8*i +: 8];
          end
          state <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wshb_pattern_slave.sv
// Directed bench for wshb_pattern_slave: registers, patterns, tracker seek
// latency, out-of-range reads, cyc abort and reset abort.
module tb_wshb_pattern_slave;

  logic clk;
  logic rst;
  int   n_err;
  int   n_checks;

  wshb_pattern_slave_if bus ();

  wshb_pattern_slave #(.HDISP(800), .VDISP(480), .WAIT_STATES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .wshb (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer; lat is the number of rising edges from request to ack (-1 on timeout).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rdata, output int lat);
    bus.we = w; bus.adr = a; bus.sel = s; bus.dat_ms = d;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    lat = -1;
    rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack) begin
        lat = c;
        rdata = bus.dat_sm;
        break;
      end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ack low after pulse", {31'b0, bus.ack}, 32'd0);
    @(posedge clk); @(negedge clk);
  endtask

  logic [31:0] rd;
  int          lat;
  int          nack;
  int          ack_at [3];
  logic [31:0] ack_dat [3];
  int          highs;

  initial begin
    n_err = 0; n_checks = 0;
    rst = 1'b1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.sel = '0; bus.dat_ms = '0;
    repeat (3) @(negedge clk);
    check("reset ack", {31'b0, bus.ack}, 32'd0);
    check("reset dat_sm", bus.dat_sm, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Registers and MODE 0
    xfer(1'b1, 32'h8000_0004, 4'hF, 32'h0012_3456, rd, lat);
    check("color write latency", lat, 32'd3);
    xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, rd, lat);
    check("mode0 pixel data", rd, 32'h0012_3456);
    check("first read seek latency", lat, 32'd4);
    xfer(1'b0, 32'h8000_0000, 4'hF, 32'h0, rd, lat);
    check("mode reg reset value", rd, 32'h0);
    xfer(1'b1, 32'h8000_0004, 4'b0010, 32'hAABB_CCDD, rd, lat);
    xfer(1'b0, 32'h8000_0004, 4'hF, 32'h0, rd, lat);
    check("color byte-lane write", rd, 32'h0012_CC56);
    xfer(1'b0, 32'h8000_0010, 4'hF, 32'h0, rd, lat);
    check("unmapped reg reads 0", rd, 32'h0);

    // MODE 3, stb held high through three sequential reads
    xfer(1'b1, 32'h8000_0000, 4'h1, 32'h0000_0003, rd, lat);
    xfer(1'b0, 32'h8000_0000, 4'hF, 32'h0, rd, lat);
    check("mode reg readback", rd, 32'h3);
    nack = 0;
    bus.we = 1'b0; bus.adr = 32'h0; bus.cyc = 1'b1; bus.stb = 1'b1;
    for (int c = 1; c <= 30 && nack < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack) begin
        ack_at[nack] = c;
        ack_dat[nack] = bus.dat_sm;
        nack++;
        bus.adr = 32'(4 * nack);
      end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    check("burst ack count", nack, 32'd3);
    check("burst ack0 cycle", ack_at[0], 32'd3);
    check("burst ack1 cycle", ack_at[1], 32'd8);
    check("burst ack2 cycle", ack_at[2], 32'd13);
    check("burst data0", ack_dat[0], 32'd0);
    check("burst data1", ack_dat[1], 32'd1);
    check("burst data2", ack_dat[2], 32'd2);
    @(posedge clk); @(negedge clk);
    check("burst gap ack low", {31'b0, bus.ack}, 32'd0);
    @(posedge clk); @(negedge clk);

    // MODE 2 checkerboard, random access then sequential
    xfer(1'b1, 32'h8000_0000, 4'h1, 32'h0000_0002, rd, lat);
    xfer(1'b0, 32'h0000_0CC0, 4'hF, 32'h0, rd, lat);
    check("mode2 idx816 data", rd, 32'h00FF_FFFF);
    check("mode2 idx816 seek latency", lat, 32'd5);
    xfer(1'b0, 32'h0000_0CC4, 4'hF, 32'h0, rd, lat);
    check("mode2 idx817 data", rd, 32'h00FF_FFFF);
    check("mode2 idx817 hit latency", lat, 32'd3);

    // MODE 1 gradient across a line wrap
    xfer(1'b1, 32'h8000_0000, 4'h1, 32'h0000_0001, rd, lat);
    xfer(1'b0, 32'h0000_0C7C, 4'hF, 32'h0, rd, lat);
    check("mode1 idx799 data", rd, 32'h001F_0080);
    check("mode1 idx799 latency", lat, 32'd4);
    xfer(1'b0, 32'h0000_0C80, 4'hF, 32'h0, rd, lat);
    check("mode1 idx800 data", rd, 32'h0000_0180);
    check("mode1 idx800 wrap latency", lat, 32'd3);

    // Out-of-range read, then tracker must reseek
    xfer(1'b0, 32'(4 * 384000), 4'hF, 32'h0, rd, lat);
    check("oor read data", rd, 32'h0);
    check("oor read latency", lat, 32'd3);
    xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, rd, lat);
    check("after oor idx0 data", rd, 32'h0000_0080);
    check("after oor idx0 latency", lat, 32'd4);

    // Drop cyc during WAIT
    bus.we = 1'b0; bus.adr = 32'h4; bus.sel = 4'hF; bus.cyc = 1'b1; bus.stb = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    highs = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack) highs++;
    end
    check("cyc abort no ack", highs, 32'd0);
    xfer(1'b0, 32'h0000_0008, 4'hF, 32'h0, rd, lat);
    check("post abort data", rd, 32'h0002_0080);
    check("post abort latency", lat, 32'd3);

    // Reset during WAIT of a register write
    bus.we = 1'b1; bus.adr = 32'h8000_0004; bus.sel = 4'hF; bus.dat_ms = 32'h00FF_FFFF;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    highs = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack) highs++;
    end
    check("reset abort no ack", highs, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    xfer(1'b0, 32'h8000_0000, 4'hF, 32'h0, rd, lat);
    check("mode after reset", rd, 32'h0);
    xfer(1'b0, 32'h8000_0004, 4'hF, 32'h0, rd, lat);
    check("color after reset", rd, 32'h0);
    xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, rd, lat);
    check("pixel after reset data", rd, 32'h0);
    check("pixel after reset latency", lat, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
